// File: rtl/othello_task_dispatcher.sv
// Host front end for the Othello solver: a task FIFO with id stamping and a result FIFO
// for solver pulses. Credit accounting bounds in-flight tasks so results are never dropped.
module othello_task_dispatcher #(
    parameter int TDEPTH = 16,
    parameter int RDEPTH = 16
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    iTaskWr,
    input  logic [63:0]             iTaskPlayer,
    input  logic [63:0]             iTaskOpponent,
    output logic                    oTaskFull,
    output logic [15:0]             oTaskId,
    output logic                    oTaskErr,
    output logic                    oValid,
    output logic [63:0]             oPlayer,
    output logic [63:0]             oOpponent,
    output logic [15:0]             oSolveTaskid,
    input  logic                    iTake,
    input  logic                    iSolved,
    input  logic [15:0]             iResTaskid,
    input  logic [7:0]              iRes,
    input  logic [15:0]             iNodes,
    output logic                    oResValid,
    input  logic                    iResRd,
    output logic [15:0]             oResTaskid,
    output logic [7:0]              oResScore,
    output logic [15:0]             oResNodes,
    output logic [$clog2(RDEPTH):0] oInflight,
    output logic                    oSpurious
);
    localparam int TAW = $clog2(TDEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam int SW  = RCW + 1;
    localparam int TW  = 144;
    localparam int RW  = 40;

    logic [TW-1:0]  tmem [TDEPTH];
    logic [RW-1:0]  rmem [RDEPTH];

    logic [TAW-1:0] twr_q, twr_d, trd_q, trd_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [TW-1:0]  thead_q, thead_d;
    logic [RAW-1:0] rwr_q, rwr_d, rrd_q, rrd_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [RW-1:0]  rhead_q, rhead_d;
    logic [15:0]    id_q, id_d;
    logic [RCW-1:0] infl_q, infl_d;
    logic           err_q, err_d;
    logic           spur_q, spur_d;

    logic           t_full, t_push, t_pop;
    logic           r_full, r_push, r_pop;
    logic           credit_ok;
    logic [SW-1:0]  committed;
    logic [TW-1:0]  t_wdata;
    logic [RW-1:0]  r_wdata;

    assign t_wdata   = {iTaskPlayer, iTaskOpponent, id_q};
    assign r_wdata   = {iResTaskid, iRes, iNodes};

    // Full is judged on the registered count, so a same-cycle take never makes room for a write.
    assign t_full    = (tcnt_q == TCW'(TDEPTH));
    assign t_push    = iTaskWr && !t_full && ((iTaskPlayer & iTaskOpponent) == 64'd0);

    // Every in-flight task or unread result owns one result slot.
    assign committed = {1'b0, infl_q} + {1'b0, rcnt_q};
    assign credit_ok = (committed < SW'(RDEPTH));
    assign oValid    = (tcnt_q != '0) && credit_ok;
    assign t_pop     = iTake && oValid;

    assign r_full    = (rcnt_q == RCW'(RDEPTH));
    assign r_pop     = iResRd && (rcnt_q != '0);
    assign r_push    = iSolved && (infl_q != '0) && (!r_full || r_pop);

    always_comb begin
        twr_d   = twr_q;
        trd_d   = trd_q;
        tcnt_d  = tcnt_q;
        thead_d = thead_q;
        if (t_push) twr_d = twr_q + TAW'(1);
        if (t_pop)  trd_d = trd_q + TAW'(1);
        case ({t_push, t_pop})
            2'b10:   tcnt_d = tcnt_q + TCW'(1);
            2'b01:   tcnt_d = tcnt_q - TCW'(1);
            default: tcnt_d = tcnt_q;
        endcase
        // Head register tracks the next head; bypass when that slot is being written now.
        if (tcnt_d != '0) begin
            if (t_push && (twr_q == trd_d)) thead_d = t_wdata;
            else                            thead_d = tmem[trd_d];
        end
    end

    always_comb begin
        rwr_d   = rwr_q;
        rrd_d   = rrd_q;
        rcnt_d  = rcnt_q;
        rhead_d = rhead_q;
        if (r_push) rwr_d = rwr_q + RAW'(1);
        if (r_pop)  rrd_d = rrd_q + RAW'(1);
        case ({r_push, r_pop})
            2'b10:   rcnt_d = rcnt_q + RCW'(1);
            2'b01:   rcnt_d = rcnt_q - RCW'(1);
            default: rcnt_d = rcnt_q;
        endcase
        if (rcnt_d != '0) begin
            if (r_push && (rwr_q == rrd_d)) rhead_d = r_wdata;
            else                            rhead_d = rmem[rrd_d];
        end
    end

    always_comb begin
        id_d   = t_push ? id_q + 16'd1 : id_q;
        err_d  = iTaskWr && !t_push;
        spur_d = spur_q || (iSolved && (infl_q == '0));
        case ({t_pop, r_push})
            2'b10:   infl_d = infl_q + RCW'(1);
            2'b01:   infl_d = infl_q - RCW'(1);
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (t_push) tmem[twr_q] <= t_wdata;
        if (r_push) rmem[rwr_q] <= r_wdata;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            twr_q   <= '0;
            trd_q   <= '0;
            tcnt_q  <= '0;
            thead_q <= '0;
            rwr_q   <= '0;
            rrd_q   <= '0;
            rcnt_q  <= '0;
            rhead_q <= '0;
            id_q    <= '0;
            infl_q  <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            twr_q   <= twr_d;
            trd_q   <= trd_d;
            tcnt_q  <= tcnt_d;
            thead_q <= thead_d;
            rwr_q   <= rwr_d;
            rrd_q   <= rrd_d;
            rcnt_q  <= rcnt_d;
            rhead_q <= rhead_d;
            id_q    <= id_d;
            infl_q  <= infl_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
        end
    end

    assign oTaskFull = t_full;
    assign oTaskId   = id_q;
    assign oTaskErr  = err_q;
    assign {oPlayer, oOpponent, oSolveTaskid} = thead_q;
    assign {oResTaskid, oResScore, oResNodes} = rhead_q;
    assign oResValid = (rcnt_q != '0);
    assign oInflight = infl_q;
    assign oSpurious = spur_q;

endmodule
